// File: rtl/lpc_pkg.sv
// Shared LPC decoder definitions: FSM states, cycle-type fields, SYNC codes, status codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lpc_pkg;

  // One state per LPC field. The bus carries one nibble per clock.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_CYCTYPE = 3'd2,  // cycle type accepted; bus now carries address nibble 1
    S_ADDR    = 3'd3,
    S_TAR_H   = 3'd4,  // turnaround host -> peripheral
    S_SYNC    = 3'd5,
    S_DATA    = 3'd6,
    S_TAR_P   = 3'd7   // turnaround peripheral -> host
  } state_e;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_SYNC_ERR    = 3'd1,
    ST_TIMEOUT     = 3'd2,
    ST_ABORT       = 3'd3,
    ST_UNSUPPORTED = 3'd4,
    ST_BAD_SYNC    = 3'd5
  } status_e;

  localparam logic [3:0] START_NIBBLE = 4'b0000;

  // Cycle type nibble: [3:2] space, [1] direction (1 = write), [0] reserved.
  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_READY_ERR  = 4'b1010;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;

  function automatic logic ct_is_write(input logic [3:0] ct);
    return ct[1];
  endfunction

  // Counter value seen while the final address nibble is on the bus.
  function automatic logic [2:0] ct_addr_last(input logic [3:0] ct);
    return (ct[3:2] == CT_MEM) ? 3'd7 : 3'd3;
  endfunction

endpackage

// File: rtl/lpc_sync_tracker.sv
// SYNC field classifier with consecutive-wait counter and timeout detection.
// Latency: classification is combinational on lpc_ad_i; counter updates on the clock edge.
// Backpressure: none; evaluated every clock while enable_i is high.
//
// Ports: clk_i/rst_ni clock and async active-low reset; lpc_ad_i bus nibble;
//        enable_i high while the parent sits in SYNC; clear_i zeroes the wait count;
//        ready_o/error_o/bad_o/timeout_o classification of the current nibble.
module lpc_sync_tracker
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 31
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] lpc_ad_i,
  input  logic       enable_i,
  input  logic       clear_i,
  output logic       ready_o,
  output logic       error_o,
  output logic       bad_o,
  output logic       timeout_o
);

  localparam logic [7:0] WAIT_LIMIT = 8'(SYNC_TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       is_ready, is_wait;

  assign is_ready = (lpc_ad_i == SYNC_READY) || (lpc_ad_i == SYNC_READY_ERR);
  assign is_wait  = (lpc_ad_i == SYNC_SHORT_WAIT) || (lpc_ad_i == SYNC_LONG_WAIT);

  assign ready_o   = enable_i && is_ready;
  assign error_o   = enable_i && (lpc_ad_i == SYNC_READY_ERR);
  assign bad_o     = enable_i && !is_ready && !is_wait;
  // The wait that would bring the count to SYNC_TIMEOUT is the one that times out.
  assign timeout_o = enable_i && is_wait && (wait_cnt_q == WAIT_LIMIT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear_i) begin
      wait_cnt_d = '0;
    end else if (enable_i) begin
      wait_cnt_d = is_wait ? wait_cnt_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC bus cycle decoder: reports IO/memory cycles, aborts, timeouts and SYNC faults.
// Latency: out_valid rises on the clock edge that samples the final nibble of a cycle.
// Backpressure: none; the host owns the bus and the decoder follows it every clock.
//
// Ports: lpc_clock, lpc_reset (async active-low), lpc_frame (LFRAME#), lpc_ad (LAD[3:0]);
//        out_cyctype_dir, out_addr, out_data, out_status hold the last reported cycle;
//        out_valid is a one-clock pulse marking a new report.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int SYNC_TIMEOUT = 31,
  parameter bit ENABLE_MEM   = 1'b1
) (
  input  logic              lpc_clock,
  input  logic              lpc_reset,
  input  logic              lpc_frame,
  input  logic [3:0]        lpc_ad,
  output logic [3:0]        out_cyctype_dir,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic [2:0]        out_status,
  output logic              out_valid
);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         cyc_q, cyc_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               err_q, err_d;

  logic               valid_q, valid_d;
  status_e            ostat_q, ostat_d;
  logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
  logic [7:0]         odata_q, odata_d;
  logic [3:0]         ocyc_q, ocyc_d;

  logic               emit;
  status_e            emit_stat;
  logic               sync_clr;
  logic               sync_ready, sync_error, sync_bad, sync_timeout;
  logic               unsupported;

  lpc_sync_tracker #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) u_sync (
    .clk_i     (lpc_clock),
    .rst_ni    (lpc_reset),
    .lpc_ad_i  (lpc_ad),
    .enable_i  (state_q == S_SYNC),
    .clear_i   (sync_clr),
    .ready_o   (sync_ready),
    .error_o   (sync_error),
    .bad_o     (sync_bad),
    .timeout_o (sync_timeout)
  );

  // Decoded from the live bus nibble on the START exit clock.
  assign unsupported = lpc_ad[3] || (lpc_ad[3:2] == CT_MEM && !ENABLE_MEM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_stat = ST_OK;
    sync_clr  = 1'b0;

    if (!lpc_frame && lpc_ad == START_NIBBLE) begin
      // New cycle from anywhere; a cycle in flight is dropped silently.
      state_d = S_START;
      cnt_d   = '0;
      cyc_d   = '0;
      addr_d  = '0;
      data_d  = '0;
      err_d   = 1'b0;
    end else if (!lpc_frame && state_q != S_IDLE && state_q != S_START) begin
      // Abort wins over any field progress; partial fields are reported as-is.
      state_d   = S_IDLE;
      cnt_d     = '0;
      emit      = 1'b1;
      emit_stat = ST_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_START: begin
          if (lpc_frame) begin
            cyc_d = lpc_ad;
            if (unsupported) begin
              state_d   = S_IDLE;
              emit      = 1'b1;
              emit_stat = ST_UNSUPPORTED;
            end else begin
              state_d = S_CYCTYPE;
            end
          end else begin
            // A start code other than ours: not our cycle.
            state_d = S_IDLE;
          end
        end
        S_CYCTYPE: begin
          addr_d  = {addr_q[27:0], lpc_ad};
          cnt_d   = 3'd1;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = {addr_q[27:0], lpc_ad};
          if (cnt_q == ct_addr_last(cyc_q)) begin
            cnt_d   = '0;
            state_d = ct_is_write(cyc_q) ? S_DATA : S_TAR_H;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_TAR_H: begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d    = '0;
            sync_clr = 1'b1;
            state_d  = S_SYNC;
          end
        end
        S_SYNC: begin
          if (sync_bad) begin
            state_d   = S_IDLE;
            emit      = 1'b1;
            emit_stat = ST_BAD_SYNC;
          end else if (sync_timeout) begin
            state_d   = S_IDLE;
            emit      = 1'b1;
            emit_stat = ST_TIMEOUT;
          end else if (sync_ready) begin
            err_d   = err_q || sync_error;
            cnt_d   = '0;
            state_d = ct_is_write(cyc_q) ? S_TAR_P : S_DATA;
          end
        end
        S_DATA: begin
          // Low nibble arrives first, so shift in from the top.
          data_d = {lpc_ad, data_q[7:4]};
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d   = '0;
            state_d = ct_is_write(cyc_q) ? S_TAR_H : S_TAR_P;
          end
        end
        S_TAR_P: begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d     = '0;
            state_d   = S_IDLE;
            emit      = 1'b1;
            emit_stat = err_q ? ST_SYNC_ERR : ST_OK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    valid_d = emit;
    ostat_d = ostat_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    ocyc_d  = ocyc_q;
    if (emit) begin
      ostat_d = emit_stat;
      oaddr_d = addr_d[ADDR_W-1:0];
      odata_d = data_d;
      ocyc_d  = cyc_d;
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ostat_q <= ST_OK;
      oaddr_q <= '0;
      odata_q <= '0;
      ocyc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ostat_q <= ostat_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      ocyc_q  <= ocyc_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_status      = ostat_q;
  assign out_addr        = oaddr_q;
  assign out_data        = odata_q;
  assign out_cyctype_dir = ocyc_q;

endmodule

// File: doc/lpc_cycle_decoder.md
LPC_CYCLE_DECODER -- requirements
Module: lpc_cycle_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, range 16..32: width of out_addr.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 31, range 1..255: maximum consecutive non-ready SYNC clocks.
REQ-003 SHALL have parameter ENABLE_MEM, default 1: if 0, memory cycles are reported as unsupported.
REQ-004 SHALL have port lpc_clock, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port lpc_reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port lpc_frame, input, 1: LFRAME#, active-low.
REQ-007 SHALL have port lpc_ad, input, 4: LAD[3:0].
REQ-008 SHALL have port out_cyctype_dir, output, 4: cycle type/direction nibble as sampled.
REQ-009 SHALL have port out_addr, output, ADDR_W: captured address.
REQ-010 SHALL have port out_data, output, 8: captured data byte.
REQ-011 SHALL have port out_status, output, 3: 0 OK, 1 SYNC_ERR, 2 TIMEOUT, 3 ABORT, 4 UNSUPPORTED, 5 BAD_SYNC.
REQ-012 SHALL have port out_valid, output, 1: one-cycle pulse; all out_* stable and meaningful while high.

Function
REQ-013 SHALL use states IDLE, START, CYCTYPE, ADDR, TAR_H, SYNC, DATA, TAR_P.
REQ-014 SHALL enter START from any state when lpc_frame=0 and lpc_ad=0000; extended LFRAME# (repeated 0000) keeps START.
REQ-015 SHALL, on lpc_frame=0 with lpc_ad!=0000 in states other than IDLE/START, go to IDLE and pulse out_valid with ABORT, retaining partially captured fields.
REQ-016 SHALL go START->CYCTYPE on first clock with lpc_frame=1; CYCTYPE samples lpc_ad directly (not a stale register).
REQ-017 SHALL treat cyctype[3:2]=00 as IO (4 address nibbles), 01 as memory (8 nibbles); 10/11, or 01 with ENABLE_MEM=0, -> IDLE with out_valid, UNSUPPORTED.
REQ-018 SHALL shift address MSB nibble first; IO address zero-extended to ADDR_W; memory address truncated to low ADDR_W bits.
REQ-019 SHALL capture data low nibble first, high nibble second.
REQ-020 SHALL sequence read: ADDR -> TAR_H(2) -> SYNC -> DATA(2) -> TAR_P(2).
REQ-021 SHALL sequence write: ADDR -> DATA(2) -> TAR_H(2) -> SYNC -> TAR_P(2).
REQ-022 SHALL not check TAR nibble values; exactly two clocks each.
REQ-023 SYNC: 0000 ready; 1010 ready with error (transfer continues, final status SYNC_ERR); 0101/0110 wait; any other code -> IDLE, out_valid, BAD_SYNC.
REQ-024 SHALL count consecutive wait clocks; on reaching SYNC_TIMEOUT -> IDLE, out_valid, TIMEOUT; counter clears on entering SYNC.
REQ-025 SHALL pulse out_valid exactly one cycle after the edge sampling the second TAR_P nibble, then return to IDLE.
REQ-026 SHALL hold out_* between pulses; fields update only at out_valid.
REQ-027 SHALL give abort precedence over every other transition in the same clock.
REQ-028 SHALL accept a new START the clock immediately after TAR_P completes (back-to-back cycles).

Reset
REQ-029 SHALL, while lpc_reset=0, force state IDLE, out_valid 0, out_status 0, out_addr 0, out_data 0, out_cyctype_dir 0, all counters 0.
REQ-030 SHALL discard any cycle in progress at reset, with no out_valid pulse.
REQ-031 SHALL honour START on the first rising edge after reset release.

Structure
REQ-032 SHALL place state encoding, cyctype codes, SYNC codes and status codes in shared package lpc_pkg.
REQ-033 SHALL implement SYNC classification and wait counter as sub-module lpc_sync_tracker (inputs lpc_ad/enable/clear; outputs ready, error, bad, timeout).

Verification
REQ-034 IO read 0x0080: frame low+0000, 0000, 0080 nibbles, TAR FF, SYNC 0000, data 5 then A -> out_valid, addr 0x00000080, data 0xA5, status 0.
REQ-035 Mem write 0xFFBC1234 data 0x3C, two 0101 waits then 0000 -> addr 0xFFBC1234, data 0x3C, status 0.
REQ-036 IO read, SYNC 0101 held 31 clocks (SYNC_TIMEOUT=31) -> one out_valid, status TIMEOUT, state IDLE.
REQ-037 lpc_frame low with lpc_ad=1111 mid-address -> out_valid, status ABORT; next START decodes normally.
REQ-038 Cyctype 1000 (DMA) -> out_valid, status UNSUPPORTED; lpc_reset asserted mid-DATA -> no pulse, outputs zero.
REQ-039 SYNC 1010 on IO write 0x002E data 0x87 -> status SYNC_ERR with addr/data captured.
